// File: rtl/writeback_buffer.sv
// Write-back buffer: FIFO of evicted dirty lines drained to pmem in the background, with snoop lookup.
// Optional WB_COALESCE_EN: pushes to an already buffered line address overwrite that entry in place.
module writeback_buffer #(
  parameter int WIDTH       = 128,
  parameter int ADDR_WIDTH  = 16,
  parameter int OFFSET_BITS = 4,
  parameter int DEPTH       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_push,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [WIDTH-1:0]      wb_data,
  output logic                  wb_full,
  output logic                  wb_empty,
  input  logic                  pmem_grant,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [WIDTH-1:0]      pmem_wdata,
  input  logic                  pmem_resp,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  lookup_hit,
  output logic [WIDTH-1:0]      lookup_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int TAG_W = ADDR_WIDTH - OFFSET_BITS;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t           state;
  state_t           state_next;
  logic [TAG_W-1:0] entry_tag   [DEPTH];
  logic [WIDTH-1:0] entry_data  [DEPTH];
  logic [DEPTH-1:0] entry_valid;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [TAG_W-1:0] push_tag;
  logic [TAG_W-1:0] lookup_tag;
  logic             coal_hit;
  logic [PTR_W-1:0] coal_idx;
  logic             alloc;
  logic             pop;
  logic             unused_offset;

  assign push_tag      = wb_addr[ADDR_WIDTH-1:OFFSET_BITS];
  assign lookup_tag    = lookup_addr[ADDR_WIDTH-1:OFFSET_BITS];
  assign unused_offset = ^{wb_addr[OFFSET_BITS-1:0], lookup_addr[OFFSET_BITS-1:0]};

  assign wb_full      = (count == CNT_W'(DEPTH));
  assign wb_empty     = (count == '0);
  assign pmem_write   = (state == WRITE);
  assign pmem_address = {entry_tag[head], {OFFSET_BITS{1'b0}}};
  assign pmem_wdata   = entry_data[head];

  // Full is judged on the registered count, so a pop in the same cycle never frees room for a push.
  assign pop   = pmem_write && pmem_resp;
  assign alloc = wb_push && !coal_hit && !wb_full;

  // Walk oldest to newest so the last match (closest to tail) wins.
  always_comb begin : lookup_search
    logic [PTR_W-1:0] idx;
    idx         = head;
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (entry_valid[idx] && (entry_tag[idx] == lookup_tag)) begin
        lookup_hit  = 1'b1;
        lookup_data = entry_data[idx];
      end
    end
  end

  always_comb begin : coalesce_search
    logic [PTR_W-1:0] idx;
    idx      = head;
    coal_hit = 1'b0;
    coal_idx = '0;
`ifdef WB_COALESCE_EN
    // The head being written out is frozen; a match there must allocate a fresh entry.
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (entry_valid[idx] && (entry_tag[idx] == push_tag) && !((i == 0) && (state == WRITE))) begin
        coal_hit = wb_push;
        coal_idx = idx;
      end
    end
`endif
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!wb_empty && pmem_grant) state_next = WRITE;
      WRITE:   if (pmem_resp) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      state <= state_next;
      if (pop) begin
        head              <= head + 1'b1;
        entry_valid[head] <= 1'b0;
      end
      if (alloc) begin
        tail              <= tail + 1'b1;
        entry_valid[tail] <= 1'b1;
      end
      case ({alloc, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Line storage is never reset; valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (alloc) begin
      entry_tag[tail]  <= push_tag;
      entry_data[tail] <= wb_data;
    end
    if (coal_hit) begin
      entry_data[coal_idx] <= wb_data;
    end
  end

endmodule

// File: tb/tb_writeback_buffer.sv
// Bench for writeback_buffer: directed scenarios plus random traffic checked against a queue model.
// Coalescing expectations follow WB_COALESCE_EN when the bench is built with it.
module tb_writeback_buffer;

  localparam int WIDTH = 128;
  localparam int AW    = 16;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             wb_push;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             wb_full;
  logic             wb_empty;
  logic             pmem_grant;
  logic             pmem_write;
  logic [AW-1:0]    pmem_address;
  logic [WIDTH-1:0] pmem_wdata;
  logic             pmem_resp;
  logic [AW-1:0]    lookup_addr;
  logic             lookup_hit;
  logic [WIDTH-1:0] lookup_data;

  writeback_buffer #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .OFFSET_BITS(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wb_push(wb_push), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_full(wb_full), .wb_empty(wb_empty),
    .pmem_grant(pmem_grant), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0]      tag;
    logic [WIDTH-1:0] data;
  } ent_t;

  ent_t q[$];
  bit   writing;
  bit   check_en;
  int   n_cmp;
  int   n_err;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_model();
    logic             exp_hit;
    logic [WIDTH-1:0] exp_data;
    exp_hit  = 1'b0;
    exp_data = '0;
    chk("pmem_write", pmem_write, writing);
    chk("wb_full", wb_full, q.size() == DEPTH);
    chk("wb_empty", wb_empty, q.size() == 0);
    if (q.size() > 0) begin
      chk("pmem_address", pmem_address, {q[0].tag, 4'h0});
      chk("pmem_wdata", pmem_wdata, q[0].data);
    end
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].tag == lookup_addr[15:4]) begin
        exp_hit  = 1'b1;
        exp_data = q[i].data;
        break;
      end
    end
    chk("lookup_hit", lookup_hit, exp_hit);
    chk("lookup_data", lookup_data, exp_data);
  endtask

  task automatic update_model();
    bit full;
    bit coal;
    bit writing_next;
    full = (q.size() == DEPTH);
    coal = 1'b0;
    if (rst) begin
      q.delete();
      writing = 1'b0;
      return;
    end
`ifdef WB_COALESCE_EN
    if (wb_push) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].tag == wb_addr[15:4] && !(i == 0 && writing)) begin
          q[i].data = wb_data;
          coal = 1'b1;
          break;
        end
      end
    end
`endif
    writing_next = writing ? !pmem_resp : (q.size() != 0 && pmem_grant);
    if (writing && pmem_resp) void'(q.pop_front());
    if (wb_push && !coal && !full) q.push_back('{tag: wb_addr[15:4], data: wb_data});
    writing = writing_next;
  endtask

  // Called at a negedge with this cycle's inputs already driven; returns at the next negedge.
  task automatic tick();
    #1;
    if (check_en) check_model();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic set_in(input logic push, input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                        input logic grant, input logic resp);
    wb_push = push; wb_addr = a; wb_data = d; pmem_grant = grant; pmem_resp = resp;
  endtask

  task automatic idle_in();
    set_in(1'b0, 16'h0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    set_in(1'b0, 16'h0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) tick();
    idle_in();
  endtask

  logic [WIDTH-1:0] line_a, line_b, line_c, line_d, line_e, line_f;

  initial begin
    n_cmp = 0; n_err = 0; check_en = 1'b0; writing = 1'b0;
    line_a = rnd_line(); line_b = rnd_line(); line_c = rnd_line();
    line_d = rnd_line(); line_e = rnd_line(); line_f = rnd_line();
    rst = 1'b1; lookup_addr = 16'h0;
    idle_in();
    @(negedge clk);
    tick(); tick();
    rst = 1'b0; check_en = 1'b1;

    // Reset state
    chk("reset_pmem_write", pmem_write, 1'b0);
    chk("reset_wb_full", wb_full, 1'b0);
    chk("reset_wb_empty", wb_empty, 1'b1);
    chk("reset_lookup_hit", lookup_hit, 1'b0);
    chk("reset_lookup_data", lookup_data, '0);

    // Single line written out
    set_in(1'b1, 16'h1230, line_a, 1'b1, 1'b0); tick();
    set_in(1'b0, 16'h0, '0, 1'b1, 1'b0); tick();
    chk("t1_write_2cyc", pmem_write, 1'b1);
    chk("t1_address", pmem_address, 16'h1230);
    chk("t1_wdata", pmem_wdata, line_a);
    set_in(1'b0, 16'h0, '0, 1'b0, 1'b0); tick(); tick();
    pmem_resp = 1'b1; tick();
    pmem_resp = 1'b0;
    chk("t1_write_dropped", pmem_write, 1'b0);
    chk("t1_empty", wb_empty, 1'b1);

    // Fill, drop on full, drain in order
    set_in(1'b1, 16'h2000, line_b, 1'b0, 1'b0); tick();
    set_in(1'b1, 16'h3000, line_c, 1'b0, 1'b0); tick();
    chk("t2_full", wb_full, 1'b1);
    set_in(1'b1, 16'h4000, line_d, 1'b0, 1'b0); tick();
    idle_in();
    lookup_addr = 16'h4000; #1;
    chk("t2_dropped_lookup", lookup_hit, 1'b0);
    chk("t2_head_addr", pmem_address, 16'h2000);
    lookup_addr = 16'h0;
    drain();
    chk("t2_drained", wb_empty, 1'b1);

    // Snoop lookup with offset bits ignored
    set_in(1'b1, 16'h5000, line_b, 1'b0, 1'b0); tick();
    idle_in();
    lookup_addr = 16'h500E; #1;
    chk("t3_hit", lookup_hit, 1'b1);
    chk("t3_data", lookup_data, line_b);
    lookup_addr = 16'h5010; #1;
    chk("t3_miss_hit", lookup_hit, 1'b0);
    chk("t3_miss_data", lookup_data, '0);
    lookup_addr = 16'h0;
    drain();

    // Push coinciding with pmem_resp, full and not full
    set_in(1'b1, 16'h2100, line_c, 1'b0, 1'b0); tick();
    set_in(1'b1, 16'h2200, line_d, 1'b0, 1'b0); tick();
    set_in(1'b0, 16'h0, '0, 1'b1, 1'b0); tick();
    set_in(1'b1, 16'h6000, line_e, 1'b0, 1'b1); tick();
    idle_in();
    lookup_addr = 16'h6000; #1;
    chk("t4_full_drop_hit", lookup_hit, 1'b0);
    chk("t4_count1_empty", wb_empty, 1'b0);
    chk("t4_count1_full", wb_full, 1'b0);
    set_in(1'b0, 16'h0, '0, 1'b1, 1'b0); tick();
    set_in(1'b1, 16'h6000, line_f, 1'b0, 1'b1); tick();
    idle_in(); #1;
    chk("t4_accept_hit", lookup_hit, 1'b1);
    chk("t4_accept_data", lookup_data, line_f);
    chk("t4_still_one", wb_full, 1'b0);
    chk("t4_head_is_new", pmem_address, 16'h6000);
    lookup_addr = 16'h0;
    drain();

    // Reset during WRITE, then a stray response
    set_in(1'b1, 16'h9000, line_a, 1'b1, 1'b0); tick();
    set_in(1'b0, 16'h0, '0, 1'b1, 1'b0); tick();
    chk("t5_writing", pmem_write, 1'b1);
    rst = 1'b1; tick();
    rst = 1'b0; idle_in(); #1;
    chk("t5_write_low", pmem_write, 1'b0);
    chk("t5_empty", wb_empty, 1'b1);
    pmem_resp = 1'b1; tick();
    pmem_resp = 1'b0; #1;
    chk("t5_late_resp_empty", wb_empty, 1'b1);
    chk("t5_late_resp_write", pmem_write, 1'b0);

    // Duplicate address push while not granted
    set_in(1'b1, 16'h7000, line_c, 1'b0, 1'b0); tick();
    set_in(1'b1, 16'h8000, line_d, 1'b0, 1'b0); tick();
    set_in(1'b1, 16'h8000, line_e, 1'b0, 1'b0); tick();
    idle_in();
    lookup_addr = 16'h8004; #1;
    chk("t6_full", wb_full, 1'b1);
    chk("t6_hit", lookup_hit, 1'b1);
`ifdef WB_COALESCE_EN
    chk("t6_data", lookup_data, line_e);
`else
    chk("t6_data", lookup_data, line_d);
`endif
    lookup_addr = 16'h0;
    drain();

    // Random traffic against the queue model
    for (int n = 0; n < 600; n++) begin
      wb_push     = ($urandom_range(0, 9) < 4);
      wb_addr     = {4'hA, 8'h0, 2'b00, 2'($urandom_range(0, 3)), 4'($urandom)};
      wb_addr     = {wb_addr[15:12], 8'($urandom_range(0, 3)), wb_addr[3:0]};
      wb_data     = rnd_line();
      pmem_grant  = ($urandom_range(0, 1) == 1);
      pmem_resp   = ($urandom_range(0, 9) < 3);
      lookup_addr = {4'hA, 8'($urandom_range(0, 4)), 4'($urandom)};
      rst         = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    idle_in();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
